urna_boletim_tx: RTL and testbench

Serial results transmitter for the voting machine. It watches the machine's vote-closed status and, on the closing event, captures the three tallies (candidate 1, candidate 2, null). It then sends one framed report over a UART-style 8N1 line to the external display/printer. This is the output end of the machine: the voting core accumulates votes, and this block reports them out.

---
 rtl/urna_boletim_tx.sv | 148 ++++++++++++++
 tb/tb_urna_boletim_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/urna_boletim_tx.sv
// Serial results transmitter: on a vote_done rising edge, snapshots the tallies and sends one 8N1 report frame.
// Optional checksum byte is enabled with `define BOLETIM_CHECKSUM_EN.
module urna_boletim_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vote_done,
   input  logic [7:0] contador_c1,
   input  logic [7:0] contador_c2,
   input  logic [7:0] contador_null,
   output logic       tx,
   output logic       busy,
   output logic       sent
);

`ifdef BOLETIM_CHECKSUM_EN
   localparam int NUM_BYTES = 6;
`else
   localparam int NUM_BYTES = 5;
`endif
   localparam int        CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
   localparam logic [7:0] HEADER    = 8'hA5;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       byte_idx;
   logic             vd_q;
   logic [7:0]       snap_c1;
   logic [7:0]       snap_c2;
   logic [7:0]       snap_null;
   logic [7:0]       total;
   logic [7:0]       cur_byte;
   logic [2:0]       next_bit;
   logic             trigger;
   logic             bit_end;

   function automatic logic [7:0] sat_total(input logic [9:0] sum);
      return (sum > 10'd255) ? 8'hFF : sum[7:0];
   endfunction

   assign total    = sat_total({2'b00, snap_c1} + {2'b00, snap_c2} + {2'b00, snap_null});
   assign trigger  = vote_done & ~vd_q;
   assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign next_bit = bit_idx + 3'd1;

`ifdef BOLETIM_CHECKSUM_EN
   logic [7:0] chk;
   assign chk = snap_c1 ^ snap_c2 ^ snap_null ^ total;
`endif

   always_comb begin
      cur_byte = 8'hFF;
      case (byte_idx)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = snap_c1;
         3'd2:    cur_byte = snap_c2;
         3'd3:    cur_byte = snap_null;
         3'd4:    cur_byte = total;
`ifdef BOLETIM_CHECKSUM_EN
         3'd5:    cur_byte = chk;
`endif
         default: cur_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         vd_q      <= 1'b1;
         snap_c1   <= '0;
         snap_c2   <= '0;
         snap_null <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         sent      <= 1'b0;
      end else begin
         vd_q <= vote_done;
         sent <= 1'b0;
         case (state)
            IDLE: begin
               // A trigger coinciding with the sent pulse is dropped, not deferred.
               if (trigger && !sent) begin
                  snap_c1   <= contador_c1;
                  snap_c2   <= contador_c2;
                  snap_null <= contador_null;
                  clk_cnt   <= '0;
                  bit_idx   <= '0;
                  byte_idx  <= '0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= next_bit;
                     tx      <= cur_byte[next_bit];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx <= '0;
                     busy     <= 1'b0;
                     sent     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_urna_boletim_tx.sv
// Bench for urna_boletim_tx: table-driven frame checks plus reset, snapshot/retrigger and fast-bit-timing sequences.
module tb_urna_boletim_tx;

`ifdef BOLETIM_CHECKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif
   localparam int CPB_A  = 4;
   localparam int CPB_B  = 2;
   localparam int FLEN_A = 10 * NB * CPB_A;
   localparam int FLEN_B = 10 * NB * CPB_B;

   typedef struct {
      logic [7:0]          c1;
      logic [7:0]          c2;
      logic [7:0]          cn;
      logic [0:5][7:0]     exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, vd_a, vd_b;
   logic [7:0] c1, c2, cn;
   logic tx_a, busy_a, sent_a, tx_b, busy_b, sent_b;

   logic cap_tx   [0:511];
   logic cap_busy [0:511];
   logic cap_sent [0:511];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   urna_boletim_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .rst(rst_a), .vote_done(vd_a),
      .contador_c1(c1), .contador_c2(c2), .contador_null(cn),
      .tx(tx_a), .busy(busy_a), .sent(sent_a)
   );

   urna_boletim_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
      .clk(clk), .rst(rst_b), .vote_done(vd_b),
      .contador_c1(c1), .contador_c2(c2), .contador_null(cn),
      .tx(tx_b), .busy(busy_b), .sent(sent_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic set_vd(input int inst, input logic v);
      if (inst == 0) vd_a = v;
      else           vd_b = v;
   endtask

   // Produce a clean 0->1 on vote_done; cycle 0 of the capture is the one right after the trigger edge.
   task automatic run_capture(input int inst, input bit disturb, input int ncyc);
      @(negedge clk);
      set_vd(inst, 1'b0);
      repeat (2) @(negedge clk);
      set_vd(inst, 1'b1);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         cap_tx[c]   = (inst == 0) ? tx_a   : tx_b;
         cap_busy[c] = (inst == 0) ? busy_a : busy_b;
         cap_sent[c] = (inst == 0) ? sent_a : sent_b;
         if (disturb) begin
            if (c == 20) begin c1 = 8'd9; c2 = 8'd9; cn = 8'd9; end
            if (c == 24) set_vd(inst, 1'b0);
            if (c == 28) set_vd(inst, 1'b1);
         end
      end
   endtask

   task automatic analyze(input string name, input int cpb, input int ncyc, input logic [0:5][7:0] exp);
      int flen, busy_cnt, sent_cnt, first_idle, bad_bits, slot, j, b;
      logic e;
      logic [7:0] d;
      flen = 10 * NB * cpb;
      busy_cnt = 0; sent_cnt = 0; first_idle = -1; bad_bits = 0;
      for (int c = 0; c < ncyc; c++) begin
         busy_cnt += int'(cap_busy[c]);
         sent_cnt += int'(cap_sent[c]);
         if (first_idle < 0 && !cap_busy[c]) first_idle = c;
      end
      check({name, " busy_len"},   first_idle, flen);
      check({name, " busy_total"}, busy_cnt, flen);
      check({name, " sent_count"}, sent_cnt, 1);
      check({name, " sent_at_end"}, cap_sent[flen], 1'b1);
      check({name, " tx_idle_after"}, cap_tx[flen], 1'b1);
      for (int jj = 0; jj < NB; jj++) begin
         for (int k = 0; k < 8; k++) d[k] = cap_tx[(jj * 10 + 1 + k) * cpb + cpb / 2];
         check($sformatf("%s byte%0d", name, jj), d, exp[jj]);
      end
      for (int c = 0; c < flen; c++) begin
         slot = c / cpb; j = slot / 10; b = slot % 10;
         e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[j][b-1];
         if (cap_tx[c] !== e) bad_bits++;
      end
      check({name, " line_bits"}, bad_bits, 0);
   endtask

   initial begin
      vec_t vecs [6];
      int   cnt;
      logic [0:5][7:0] e331;

      vecs[0] = '{8'd3,   8'd5,   8'd1,  {8'hA5, 8'h03, 8'h05, 8'h01, 8'h09, 8'h0E}};
      vecs[1] = '{8'd200, 8'd100, 8'd10, {8'hA5, 8'hC8, 8'h64, 8'h0A, 8'hFF, 8'h59}};
      vecs[2] = '{8'd1,   8'd0,   8'd0,  {8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00}};
      vecs[3] = '{8'd255, 8'd0,   8'd0,  {8'hA5, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00}};
      vecs[4] = '{8'd85,  8'd85,  8'd85, {8'hA5, 8'h55, 8'h55, 8'h55, 8'hFF, 8'hAA}};
      vecs[5] = '{8'd128, 8'd128, 8'd0,  {8'hA5, 8'h80, 8'h80, 8'h00, 8'hFF, 8'hFF}};
      e331 = vecs[0].exp;

      rst_a = 1'b1; rst_b = 1'b1; vd_a = 1'b1; vd_b = 1'b1;
      c1 = 8'd0; c2 = 8'd0; cn = 8'd0;
      repeat (3) @(negedge clk);
      check("reset tx_a", tx_a, 1'b1);
      check("reset busy_a", busy_a, 1'b0);
      check("reset sent_a", sent_a, 1'b0);
      check("reset tx_b", tx_b, 1'b1);

      // vote_done already high at reset release must not start a frame
      rst_a = 1'b0; rst_b = 1'b0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         cnt += int'(busy_a) + int'(busy_b) + int'(sent_a) + int'(sent_b);
      end
      check("vd_high_at_release no_frame", cnt, 0);

      for (int i = 0; i < 6; i++) begin
         c1 = vecs[i].c1; c2 = vecs[i].c2; cn = vecs[i].cn;
         run_capture(0, 1'b0, FLEN_A + 40);
         analyze($sformatf("vec%0d", i), CPB_A, FLEN_A + 40, vecs[i].exp);
      end

      // tallies change and vote_done toggles mid-frame: original values, no second frame
      c1 = 8'd3; c2 = 8'd5; cn = 8'd1;
      run_capture(0, 1'b1, FLEN_A + 40);
      analyze("snapshot", CPB_A, FLEN_A + 40, e331);

      c1 = 8'd1; c2 = 8'd0; cn = 8'd0;
      run_capture(0, 1'b0, FLEN_A + 40);
      analyze("retrigger", CPB_A, FLEN_A + 40, vecs[2].exp);

      // reset asserted during byte index 2
      c1 = 8'd3; c2 = 8'd5; cn = 8'd1;
      @(negedge clk); vd_a = 1'b0;
      repeat (2) @(negedge clk); vd_a = 1'b1;
      repeat ((2 * 10 + 3) * CPB_A) @(negedge clk);
      check("midreset busy_before", busy_a, 1'b1);
      rst_a = 1'b1;
      @(posedge clk); #1;
      check("midreset tx", tx_a, 1'b1);
      check("midreset busy", busy_a, 1'b0);
      check("midreset sent", sent_a, 1'b0);
      @(negedge clk); rst_a = 1'b0;
      cnt = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         cnt += int'(busy_a) + int'(sent_a) + int'(!tx_a);
      end
      check("midreset quiet_after", cnt, 0);

      // two clocks per bit
      c1 = 8'd200; c2 = 8'd100; cn = 8'd10;
      run_capture(1, 1'b0, FLEN_B + 20);
      analyze("cpb2", CPB_B, FLEN_B + 20, vecs[1].exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
